traffic_light_ctrl: RTL

Two-road intersection sequencer for north-south (NS) and east-west (EW) lamp heads, driving both as `colors` values (red/yellow/green). Moore FSM with a tick-driven phase timer: green rests on a road until the cross road or a pedestrian demands service, then steps through yellow, all-red and an optional pedestrian walk phase. Sits between the sensor/button inputs and the lamp decoders in the traffic lights lab top level.

---
 rtl/traffic_light_ctrl_pkg.sv | 26 ++
 rtl/traffic_light_ctrl_phase_timer.sv | 30 +++
 rtl/traffic_light_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the intersection sequencer: lamp colours and controller phases.
// The colors encoding is owned by the lamp decoders; 2'b11 is deliberately unused.
package traffic_light_ctrl_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } colors;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        WALK_A    = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        RED_B     = 3'd6,
        WALK_B    = 3'd7
    } tl_state_t;

    function automatic logic is_walk(input tl_state_t s);
        return (s == WALK_A) || (s == WALK_B);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Down-counting phase timer: loaded on phase entry, counts ticks, flags expiry.
// done fires on the tick that takes the count to zero, so a phase of N lasts exactly N ticks.
module phase_timer #(
    parameter int WIDTH       = 3,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(RESET_VALUE);
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0) || ((count == WIDTH'(1)) && tick);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: Moore FSM with rest-in-green, yellow, all-red and
// optional pedestrian walk phases; lamp outputs are registered from the next state.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  car_ns,
    input  logic  car_ew,
    input  logic  ped_req,
    output colors light_ns,
    output colors light_ew,
    output logic  walk,
    output logic  ped_pending
);

    localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_RW    = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
    localparam int MAX_TICKS = (MAX_GY > MAX_RW) ? MAX_GY : MAX_RW;
    localparam int TIMER_W   = (MAX_TICKS < 1) ? 1 : $clog2(MAX_TICKS + 1);

    if ((GREEN_TICKS < 1) || (YELLOW_TICKS < 1) || (ALLRED_TICKS < 1) || (WALK_TICKS < 1)) begin : g_bad_params
        $warning("traffic_light_ctrl: phase durations of 0 ticks are not supported");
    end

    tl_state_t          state;
    tl_state_t          next_state;
    logic               load;
    logic [TIMER_W-1:0] load_value;
    logic               done;
    logic               entering_walk;
    colors              ns_next;
    colors              ew_next;

    phase_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (GREEN_TICKS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .done       (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NS_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            NS_GREEN:  if (done && (car_ew || ped_pending)) next_state = NS_YELLOW;
            NS_YELLOW: if (done) next_state = RED_A;
            RED_A:     if (done) next_state = ped_pending ? WALK_A : EW_GREEN;
            WALK_A:    if (done) next_state = EW_GREEN;
            EW_GREEN:  if (done && (car_ns || ped_pending)) next_state = EW_YELLOW;
            EW_YELLOW: if (done) next_state = RED_B;
            RED_B:     if (done) next_state = ped_pending ? WALK_B : NS_GREEN;
            WALK_B:    if (done) next_state = NS_GREEN;
            default:   next_state = NS_GREEN;
        endcase
    end

    // A state change reloads the timer; the load wins over a coincident tick.
    always_comb begin
        load       = (next_state != state);
        load_value = '0;
        unique case (next_state)
            NS_GREEN, EW_GREEN:   load_value = TIMER_W'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: load_value = TIMER_W'(YELLOW_TICKS);
            RED_A, RED_B:         load_value = TIMER_W'(ALLRED_TICKS);
            WALK_A, WALK_B:       load_value = TIMER_W'(WALK_TICKS);
            default:              load_value = TIMER_W'(GREEN_TICKS);
        endcase
    end

    always_comb begin
        ns_next = RED;
        ew_next = RED;
        unique case (next_state)
            NS_GREEN:  ns_next = GREEN;
            NS_YELLOW: ns_next = YELLOW;
            EW_GREEN:  ew_next = GREEN;
            EW_YELLOW: ew_next = YELLOW;
            default: begin
                ns_next = RED;
                ew_next = RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            light_ns <= GREEN;
            light_ew <= RED;
            walk     <= 1'b0;
        end else begin
            light_ns <= ns_next;
            light_ew <= ew_next;
            walk     <= is_walk(next_state);
        end
    end

    // Serving the walk clears the request; presses during the walk itself are ignored.
    assign entering_walk = is_walk(next_state) && !is_walk(state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending <= 1'b0;
        end else if (entering_walk) begin
            ped_pending <= 1'b0;
        end else if (ped_req && !is_walk(state)) begin
            ped_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((light_ns == RED) || (light_ew == RED))
                else $error("traffic_light_ctrl: both roads shown non-red");
            assert ((light_ns != colors'(2'b11)) && (light_ew != colors'(2'b11)))
                else $error("traffic_light_ctrl: illegal lamp encoding");
        end
    end

endmodule
